// File: rtl/ps2_receiver.sv
// PS/2 device-to-host frame receiver: synchronizes the raw bus, decodes 11-bit frames, flags bad or stalled frames.
// Optional build macro PS2_PARITY_CHECK_EN enables rejection of frames with even data+parity weight.
module ps2_receiver #(
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2Clk,
    input  logic       ps2Data,
    output logic [7:0] code,
    output logic       valid,
    output logic       frameErr
);

    localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 16) ? $clog2(TIMEOUT_CYCLES + 1) : 16;

    typedef enum logic [1:0] {
        S_IDLE,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    logic             r_clk_meta;
    logic             r_clk_sync;
    logic             r_clk_hist;
    logic             r_data_meta;
    logic             r_data_sync;
    state_t           r_state;
    logic [2:0]       r_bit_cnt;
    logic [7:0]       r_shift;
    logic             r_parity;
    logic [CNT_W-1:0] r_idle_cnt;
    logic [7:0]       r_code;
    logic             r_valid;
    logic             r_frame_err;

    state_t           w_next_state;
    logic             w_fall;
    logic             w_timeout;
    logic             w_parity_ok;
    logic             w_frame_good;
    logic             w_emit_valid;
    logic             w_emit_err;

    // The bus idles high, so the synchronizers reset to 1 to avoid a false edge after reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_clk_meta  <= 1'b1;
            r_clk_sync  <= 1'b1;
            r_clk_hist  <= 1'b1;
            r_data_meta <= 1'b1;
            r_data_sync <= 1'b1;
        end else begin
            // NOTE: non-blocking assignments make every flop sample the pre-edge value, which is what builds the chain.
            r_clk_meta  <= ps2Clk;
            r_clk_sync  <= r_clk_meta;
            r_clk_hist  <= r_clk_sync;
            r_data_meta <= ps2Data;
            r_data_sync <= r_data_meta;
        end
    end

    assign w_fall    = r_clk_hist & ~r_clk_sync;
    assign w_timeout = (r_state != S_IDLE) && !w_fall && (r_idle_cnt >= CNT_W'(TIMEOUT_CYCLES));

`ifdef PS2_PARITY_CHECK_EN
    assign w_parity_ok = ^{r_shift, r_parity};
`else
    // Parity is captured but never causes a rejection in this build.
    assign w_parity_ok = 1'b1 | r_parity;
`endif

    assign w_frame_good = r_data_sync & w_parity_ok;

    always_comb begin
        // NOTE: defaults first so no path leaves an output unassigned and infers a latch.
        w_next_state = r_state;
        w_emit_valid = 1'b0;
        w_emit_err   = 1'b0;
        if (w_timeout) begin
            w_next_state = S_IDLE;
            w_emit_err   = 1'b1;
        end else if (w_fall) begin
            unique case (r_state)
                S_IDLE:   if (!r_data_sync) w_next_state = S_DATA;
                S_DATA:   if (r_bit_cnt == 3'd7) w_next_state = S_PARITY;
                S_PARITY: w_next_state = S_STOP;
                S_STOP: begin
                    w_next_state = S_IDLE;
                    w_emit_valid = w_frame_good;
                    w_emit_err   = ~w_frame_good;
                end
                default:  w_next_state = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next_state;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_bit_cnt <= '0;
            r_shift   <= '0;
            r_parity  <= 1'b0;
        end else if (w_fall && !w_timeout) begin
            if (r_state == S_IDLE && !r_data_sync) begin
                r_bit_cnt <= '0;
            end else if (r_state == S_DATA) begin
                r_shift   <= {r_data_sync, r_shift[7:1]};
                r_bit_cnt <= r_bit_cnt + 3'd1;
            end else if (r_state == S_PARITY) begin
                r_parity  <= r_data_sync;
            end
        end
    end

    // Counts clk cycles since the last ps2Clk fall while a frame is in progress.
    always_ff @(posedge clk) begin
        if (rst || r_state == S_IDLE || w_fall || w_timeout) r_idle_cnt <= '0;
        else                                                 r_idle_cnt <= r_idle_cnt + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_code      <= 8'h00;
            r_valid     <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            if (w_emit_valid) r_code <= r_shift;
            r_valid     <= w_emit_valid;
            r_frame_err <= w_emit_err;
        end
    end

    assign code     = r_code;
    assign valid    = r_valid;
    assign frameErr = r_frame_err;

endmodule

// File: tb/tb_ps2_receiver.sv
// Directed bench for ps2_receiver: good frames, stop/parity errors, timeout, idle noise and mid-frame reset.
`timescale 1ns/1ps
module tb_ps2_receiver;

    localparam int TO = 1000;
    localparam int FAST = 50;

`ifdef PS2_PARITY_CHECK_EN
    localparam int PAR_EXP_VALID = 0;
    localparam int PAR_EXP_ERR   = 1;
    localparam int PAR_EXP_CODE  = 8'h1B;
`else
    localparam int PAR_EXP_VALID = 1;
    localparam int PAR_EXP_ERR   = 0;
    localparam int PAR_EXP_CODE  = 8'h4B;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       ps2Clk = 1'b1;
    logic       ps2Data = 1'b1;
    logic [7:0] code;
    logic       valid;
    logic       frameErr;

    int   n_checks = 0;
    int   n_errors = 0;
    int   cyc = 0;
    int   last_fall_cyc = 0;
    int   valid_cnt = 0;
    int   err_cnt = 0;
    int   overlap_cnt = 0;
    logic [7:0] code_log [16];

    ps2_receiver #(.TIMEOUT_CYCLES(TO)) dut (
        .clk      (clk),
        .rst      (rst),
        .ps2Clk   (ps2Clk),
        .ps2Data  (ps2Data),
        .code     (code),
        .valid    (valid),
        .frameErr (frameErr)
    );

    always #10 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (valid) begin
            code_log[valid_cnt % 16] <= code;
            valid_cnt <= valid_cnt + 1;
        end
        if (frameErr) err_cnt <= err_cnt + 1;
        if (valid && frameErr) overlap_cnt <= overlap_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic ps2_bit(input logic b, input int half);
        ps2Data = b;
        wait_cycles(half);
        ps2Clk = 1'b0;
        last_fall_cyc = cyc;
        wait_cycles(half);
        ps2Clk = 1'b1;
    endtask

    // Bits go out start, d0..d7, parity, stop; nbits truncates the frame.
    task automatic send_frame(input logic [7:0] d, input logic par, input logic stop,
                              input int half, input int nbits);
        logic [10:0] bits;
        bits = {stop, par, d, 1'b0};
        for (int i = 0; i < nbits; i++) ps2_bit(bits[i], half);
        ps2Data = 1'b1;
    endtask

    initial begin
        int v0;
        int e0;
        int lat;
        bit seen;

        wait_cycles(5);
        check("rst_code", code, 8'h00);
        check("rst_valid", valid, 1'b0);
        check("rst_frameErr", frameErr, 1'b0);
        rst = 1'b0;
        wait_cycles(5);

        // 0x1D at a slow bus rate, well inside the timeout
        v0 = valid_cnt; e0 = err_cnt;
        send_frame(8'h1D, 1'b1, 1'b1, 300, 11);
        wait_cycles(20);
        check("f1d_valid_pulses", valid_cnt - v0, 1);
        check("f1d_err_pulses", err_cnt - e0, 0);
        check("f1d_code", code, 8'h1D);

        // Break code prefix then key, back-to-back
        v0 = valid_cnt; e0 = err_cnt;
        send_frame(8'hF0, 1'b1, 1'b1, FAST, 11);
        send_frame(8'h1B, 1'b1, 1'b1, FAST, 11);
        wait_cycles(20);
        check("b2b_valid_pulses", valid_cnt - v0, 2);
        check("b2b_first_code", code_log[v0 % 16], 8'hF0);
        check("b2b_second_code", code_log[(v0 + 1) % 16], 8'h1B);
        check("b2b_err_pulses", err_cnt - e0, 0);

        // Bad stop bit
        v0 = valid_cnt; e0 = err_cnt;
        send_frame(8'h44, 1'b1, 1'b0, FAST, 11);
        wait_cycles(20);
        check("stop_err_pulses", err_cnt - e0, 1);
        check("stop_valid_pulses", valid_cnt - v0, 0);
        check("stop_code_held", code, 8'h1B);

        // Wrong parity (0x4B has even weight, correct parity would be 1)
        v0 = valid_cnt; e0 = err_cnt;
        send_frame(8'h4B, 1'b0, 1'b1, FAST, 11);
        wait_cycles(20);
        check("par_valid_pulses", valid_cnt - v0, PAR_EXP_VALID);
        check("par_err_pulses", err_cnt - e0, PAR_EXP_ERR);
        check("par_code", code, PAR_EXP_CODE);

        // A clock fall with data high in IDLE is noise: no output, and no timeout while idle
        v0 = valid_cnt; e0 = err_cnt;
        ps2_bit(1'b1, FAST);
        wait_cycles(TO + 100);
        check("noise_valid_pulses", valid_cnt - v0, 0);
        check("noise_err_pulses", err_cnt - e0, 0);

        // Start plus 5 data bits, then the bus stalls
        v0 = valid_cnt; e0 = err_cnt;
        send_frame(8'h1D, 1'b1, 1'b1, FAST, 6);
        seen = 1'b0;
        lat = 0;
        for (int i = 0; i < TO + 200 && !seen; i++) begin
            @(posedge clk);
            if (err_cnt != e0) begin
                seen = 1'b1;
                lat = cyc - last_fall_cyc;
            end
        end
        #1;
        check("timeout_seen", seen, 1'b1);
        check("timeout_latency_in_window", (lat >= TO) && (lat <= TO + 10), 1'b1);
        wait_cycles(TO + 100);
        check("timeout_single_pulse", err_cnt - e0, 1);
        check("timeout_no_valid", valid_cnt - v0, 0);
        check("timeout_code_held", code, PAR_EXP_CODE);

        v0 = valid_cnt; e0 = err_cnt;
        send_frame(8'h1D, 1'b1, 1'b1, FAST, 11);
        wait_cycles(20);
        check("post_to_valid_pulses", valid_cnt - v0, 1);
        check("post_to_code", code, 8'h1D);
        check("post_to_err_pulses", err_cnt - e0, 0);

        // Reset after the 4th data bit, then a full frame
        v0 = valid_cnt; e0 = err_cnt;
        send_frame(8'h1D, 1'b1, 1'b1, FAST, 5);
        rst = 1'b1;
        wait_cycles(1);
        rst = 1'b0;
        wait_cycles(1);
        check("midrst_code_cleared", code, 8'h00);
        wait_cycles(TO + 100);
        check("midrst_valid_pulses", valid_cnt - v0, 0);
        check("midrst_err_pulses", err_cnt - e0, 0);
        send_frame(8'h44, 1'b1, 1'b1, FAST, 11);
        wait_cycles(20);
        check("midrst_frame_valid", valid_cnt - v0, 1);
        check("midrst_frame_code", code, 8'h44);
        check("midrst_frame_err", err_cnt - e0, 0);

        check("valid_err_overlap", overlap_cnt, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/ps2_receiver.md
PS2_RECEIVER -- requirements
Module: ps2_receiver

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 50000, meaning clk cycles without a ps2Clk falling edge before a partial frame is abandoned (1 ms at 50 MHz).
REQ-002 SHALL have port clk, input, 1, system clock, 50 MHz.
REQ-003 SHALL have port rst, input, 1, reset; one clock, reset synchronous and active-high.
REQ-004 SHALL have port ps2Clk, input, 1, raw PS/2 clock, asynchronous to clk, 10-16.7 kHz.
REQ-005 SHALL have port ps2Data, input, 1, raw PS/2 data, asynchronous to clk.
REQ-006 SHALL have port code, output, 8, last correctly received scan-code byte.
REQ-007 SHALL have port valid, output, 1, one-cycle pulse marking a new code.
REQ-008 SHALL have port frameErr, output, 1, one-cycle pulse marking a discarded frame.

Function
REQ-009 SHALL pass ps2Clk and ps2Data each through a 2-flop synchronizer, plus one further ps2Clk history flop.
REQ-010 SHALL raise internal fallEdge for one cycle when the history flop is 1 and the synchronized ps2Clk is 0; the synchronized ps2Data is sampled in that same cycle.
REQ-011 SHALL run FSM states IDLE, DATA, PARITY, STOP, advancing only on fallEdge cycles, except for timeout.
REQ-012 In IDLE, on fallEdge with data 0 (start bit), SHALL clear the 3-bit bit counter and go to DATA; with data 1, SHALL stay in IDLE with no output.
REQ-013 In DATA, SHALL shift data into an 8-bit shift register LSB first on each fallEdge; after the 8th bit (counter 7) SHALL go to PARITY.
REQ-014 In PARITY, SHALL store the sampled bit and go to STOP.
REQ-015 The frame is good when the STOP-state fallEdge samples data 1 and the parity check of REQ-025 passes.
REQ-016 On a STOP-state fallEdge with a good frame, SHALL load code from the shift register and assert valid in the next clk cycle, for exactly one cycle, then go to IDLE.
REQ-017 On a STOP-state fallEdge with a bad frame, SHALL leave code unchanged, pulse frameErr for one cycle at the same timing as valid, and go to IDLE.
REQ-018 code SHALL hold its value between valid pulses.
REQ-019 valid and frameErr SHALL never be high together.
REQ-020 A 16-bit-or-wider idle counter SHALL clear on every fallEdge and increment otherwise while not in IDLE; it SHALL be held at 0 in IDLE.
REQ-021 When the idle counter reaches TIMEOUT_CYCLES outside IDLE, SHALL go to IDLE and pulse frameErr once.
REQ-022 If timeout and fallEdge coincide, fallEdge SHALL win and the counter SHALL clear.
REQ-023 SHALL not interpret codes: 0xF0 and 0xE0 prefixes are delivered as ordinary bytes.

Reset
REQ-024 While rst is high: state IDLE, code=0x00, valid=0, frameErr=0, counters and shift register 0, synchronizer and history flops 1 (idle-high bus). Reset mid-frame SHALL discard the partial frame and emit no pulse.

Configuration
REQ-025 With macro PS2_PARITY_CHECK_EN defined, a frame SHALL be good only if data bits plus parity bit have odd weight; without it, the parity bit SHALL be sampled but ignored.

Verification
REQ-026 Frame 0x1D, parity 1, stop 1 at 12 kHz -> exactly one valid pulse, code=0x1D, frameErr stays 0.
REQ-027 Frames 0xF0 then 0x1B, back-to-back -> two valid pulses, with code 0xF0 then 0x1B.
REQ-028 Frame 0x44 with stop bit 0 -> one frameErr pulse, no valid, code keeps its previous value.
REQ-029 Frame 0x4B with parity 0 (wrong) -> with PS2_PARITY_CHECK_EN: frameErr pulse, code unchanged; without the macro: valid pulse, code=0x4B.
REQ-030 Start bit plus 5 data bits, then ps2Clk held high for more than 50000 cycles -> one frameErr pulse at the timeout; a following 0x1D frame is received correctly.
REQ-031 rst for 1 cycle after the 4th data bit, then a full 0x44 frame -> no pulse from the aborted frame, then valid pulse with code=0x44.
